// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between a read-only
// fetch port and a read/write data port. Every access walks
// IDLE -> ISSUE -> WAIT -> RESP, so the ack for a request sampled in IDLE
// appears three cycles later. When both ports request together, the port
// that was not granted last time wins.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              f_ack,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  logic   last_grant_d;  // 1: data port was granted last, 0: fetch port
  logic   grant_d;       // owner of the access in flight
  logic   op_write;      // access in flight is a data-port write
  logic   pick_d;        // data port wins if a grant happens this cycle

  // Round-robin choice: a lone requester wins; on contention the port that
  // did not win last time takes the grant.
  always_comb begin
    pick_d = 1'b0;
    if (d_req && (!f_req || !last_grant_d)) begin
      pick_d = 1'b1;
    end
  end

  // Access sequencer: every output is a register so the RAM and both ports
  // see glitch-free controls, and the address/data stay put until RESP ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      grant_d      <= 1'b0;
      op_write     <= 1'b0;
      f_ack        <= 1'b0;
      d_ack        <= 1'b0;
      rdata        <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_we       <= 1'b0;
      ram_re       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            grant_d      <= pick_d;
            last_grant_d <= pick_d;
            op_write     <= pick_d & d_we;
            ram_addr     <= pick_d ? d_addr : f_addr;
            ram_wdata    <= pick_d ? d_wdata : '0;
            ram_we       <= pick_d & d_we;
            ram_re       <= ~(pick_d & d_we);
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          ram_re <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (!op_write) begin
            rdata <= ram_rdata;
          end
          f_ack <= ~grant_d;
          d_ack <= grant_d;
          state <= RESP;
        end
        RESP: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a behavioural
// registered-output RAM whose words start out as 0x01000000 | address.
module tb_mem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              f_ack;
  logic              d_ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              busy;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int check_count = 0;
  int error_count = 0;
  int cycle = 0;
  int we_count = 0;
  int overlap_count = 0;
  int f_ack_count = 0;
  int d_ack_count = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .f_ack(f_ack), .d_ack(d_ack), .rdata(rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Synchronous RAM: write on enabled edge, read data registered one cycle.
  always @(posedge clock) begin
    cycle++;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // Mid-cycle tallies of write strobes, illegal overlaps and ack pulses.
  always @(negedge clock) begin
    if (ram_we) we_count++;
    if (ram_re && ram_we) overlap_count++;
    if (f_ack) f_ack_count++;
    if (d_ack) d_ack_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic fr, input logic [ADDR_W-1:0] fa,
                               input logic dr, input logic dw,
                               input logic [ADDR_W-1:0] da,
                               input logic [DATA_W-1:0] dwd);
    f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  // One isolated access from IDLE, checked in every phase.
  task automatic doAccess(input string tag, input logic is_data, input logic we,
                          input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata,
                          input logic [DATA_W-1:0] exp_rdata);
    logic wr;
    wr = is_data & we;
    if (is_data) applyStimulus(1'b0, '0, 1'b1, we, addr, wdata);
    else         applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, '0);
    tick;
    checkOutput({tag, "_issue_re"}, ram_re, !wr);
    checkOutput({tag, "_issue_we"}, ram_we, wr);
    checkOutput({tag, "_issue_addr"}, ram_addr, addr);
    checkOutput({tag, "_issue_busy"}, busy, 1);
    if (wr) checkOutput({tag, "_issue_wdata"}, ram_wdata, wdata);
    tick;
    checkOutput({tag, "_wait_ctl"}, {ram_re, ram_we}, 0);
    checkOutput({tag, "_wait_addr"}, ram_addr, addr);
    tick;
    checkOutput({tag, "_resp_ack"}, {f_ack, d_ack}, is_data ? 2'b01 : 2'b10);
    checkOutput({tag, "_resp_rdata"}, rdata, exp_rdata);
    checkOutput({tag, "_resp_addr"}, ram_addr, addr);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    checkOutput({tag, "_idle"}, {busy, f_ack, d_ack}, 0);
  endtask

  // Bounded wait for any ack; at stays -1 if none arrives.
  task automatic waitAck(output int at, output logic [1:0] which);
    at = -1;
    which = 2'b00;
    for (int i = 0; i < 12 && at < 0; i++) begin
      tick;
      if (f_ack || d_ack) begin
        at = cycle;
        which = {f_ack, d_ack};
      end
    end
  endtask

  initial begin
    int at, prev_at, we_before, f_before, d_before;
    logic [1:0] which;
    logic [DATA_W-1:0] exp;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0100_0000 | i;
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    tick;
    checkOutput("rst_ctl", {f_ack, d_ack, ram_re, ram_we, busy}, 0);
    checkOutput("rst_addr", ram_addr, 0);
    checkOutput("rst_wdata", ram_wdata, 0);
    checkOutput("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick;

    // Single data read, then write followed by read-back.
    doAccess("rd95", 1'b1, 1'b0, 9'h095, '0, 32'h0100_0095);
    we_before = we_count;
    doAccess("wr87", 1'b1, 1'b1, 9'h087, 32'hFFFF_FFF0, 32'h0100_0095);
    checkOutput("wr87_pulses", we_count - we_before, 1);
    doAccess("rd87", 1'b1, 1'b0, 9'h087, '0, 32'hFFFF_FFF0);

    // Fetch-only stream with req held, address advanced on each ack.
    we_before = we_count;
    prev_at = -1;
    applyStimulus(1'b1, '0, 1'b0, 1'b0, '0, '0);
    for (int a = 0; a <= 20; a++) begin
      waitAck(at, which);
      checkOutput("fetch_timeout", at < 0, 0);
      checkOutput("fetch_ack", which, 2'b10);
      exp = 32'h0100_0000 | a;
      checkOutput("fetch_rdata", rdata, exp);
      if (prev_at >= 0) checkOutput("fetch_spacing", at - prev_at, 4);
      prev_at = at;
      f_addr = ADDR_W'(a + 1);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    tick;
    checkOutput("fetch_no_we", we_count - we_before, 0);

    // Contention after reset: data first, then strict alternation.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    applyStimulus(1'b1, 9'h010, 1'b1, 1'b0, 9'h020, '0);
    prev_at = -1;
    for (int k = 0; k < 4; k++) begin
      waitAck(at, which);
      checkOutput("cont_timeout", at < 0, 0);
      checkOutput("cont_order", which, (k % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput("cont_rdata", rdata, (k % 2 == 0) ? 32'h0100_0020 : 32'h0100_0010);
      if (prev_at >= 0) checkOutput("cont_spacing", at - prev_at, 4);
      prev_at = at;
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    tick;

    // Reset asserted while a data read sits in WAIT.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 9'h033, '0);
    tick;
    tick;
    d_before = d_ack_count;
    reset = 1'b1;
    #1;
    checkOutput("wrst_ctl", {f_ack, d_ack, ram_re, ram_we, busy}, 0);
    checkOutput("wrst_addr", ram_addr, 0);
    checkOutput("wrst_rdata", rdata, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick;
    reset = 1'b0;
    tick;
    tick;
    tick;
    checkOutput("wrst_no_ack", d_ack_count - d_before, 0);
    doAccess("after_rst", 1'b1, 1'b0, 9'h044, '0, 32'h0100_0044);

    // Fetch request raised during a data access's ISSUE cycle.
    f_before = f_ack_count;
    d_before = d_ack_count;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 9'h055, '0);
    tick;
    f_req = 1'b1;
    f_addr = 9'h066;
    tick;
    checkOutput("busy_wait_ack", {f_ack, d_ack}, 0);
    tick;
    checkOutput("busy_d_ack", {f_ack, d_ack}, 2'b01);
    checkOutput("busy_d_rdata", rdata, 32'h0100_0055);
    prev_at = cycle;
    d_req = 1'b0;
    waitAck(at, which);
    checkOutput("busy_f_timeout", at < 0, 0);
    checkOutput("busy_f_ack", which, 2'b10);
    checkOutput("busy_f_spacing", at - prev_at, 4);
    checkOutput("busy_f_rdata", rdata, 32'h0100_0066);
    f_req = 1'b0;
    tick;
    tick;
    tick;
    checkOutput("busy_f_count", f_ack_count - f_before, 1);
    checkOutput("busy_d_count", d_ack_count - d_before, 1);

    checkOutput("re_we_overlap", overlap_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
